// File: rtl/mmc1_serial_core.sv
// MMC1 (SxROM) serial register core: 5-write serial loader plus PRG/CHR/WRAM/mirroring decode.
// Optional macro MMC1_WRITE_FILTER_EN rejects a $8000+ write on the ce cycle right after another one.
module mmc1_serial_core #(
    parameter logic [3:0] LAST_BANK   = 4'hF,
    parameter logic [8:0] WRAM_PREFIX = 9'b11_1100_000,
    parameter logic [4:0] CHR_PREFIX  = 5'b10000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] prg_ain,
    input  logic [7:0]  prg_din,
    input  logic        prg_write,
    input  logic [13:0] chr_ain,
    output logic [21:0] prg_aout,
    output logic [21:0] chr_aout,
    output logic [3:0]  mmc1_chr,
    output logic [21:0] mmc1_aout,
    output logic        vram_a10,
    output logic        wram_ce
);

    logic [4:0] shift;
    logic [4:0] control;
    logic [4:0] chr0;
    logic [4:0] chr1;
    logic [4:0] prg;
    logic [4:0] nxt;
    logic       filtered;
    logic       accept;
    logic [3:0] prg_bank;
    logic [4:0] chr_bank;
    logic       unused_bits;

`ifdef MMC1_WRITE_FILTER_EN
    // Remembers whether the previous ce cycle was a mapper write, so RMW double writes drop out.
    logic wr_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_prev <= 1'b0;
        end else if (ce) begin
            wr_prev <= prg_write && prg_ain[15];
        end
    end

    assign filtered = wr_prev;
`else
    assign filtered = 1'b0;
`endif

    assign accept = ce && prg_write && prg_ain[15] && !filtered;
    assign nxt    = {prg_din[0], shift[4:1]};

    // The 1 in shift walks down to bit0; seeing it there means this write is the fifth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift   <= 5'b10000;
            control <= 5'b01100;
            chr0    <= 5'd0;
            chr1    <= 5'd0;
            prg     <= 5'd0;
        end else if (accept) begin
            if (prg_din[7]) begin
                shift   <= 5'b10000;
                control <= control | 5'b01100;
            end else if (shift[0]) begin
                shift <= 5'b10000;
                case (prg_ain[14:13])
                    2'd0:    control <= nxt;
                    2'd1:    chr0    <= nxt;
                    2'd2:    chr1    <= nxt;
                    default: prg     <= nxt;
                endcase
            end else begin
                shift <= nxt;
            end
        end
    end

    always_comb begin
        prg_bank = 4'd0;
        prg_aout = {6'b0, prg_ain};
        wram_ce  = 1'b0;
        if (prg_ain[15]) begin
            case (control[3:2])
                2'b10:   prg_bank = prg_ain[14] ? prg[3:0] : 4'd0;
                2'b11:   prg_bank = prg_ain[14] ? LAST_BANK : prg[3:0];
                default: prg_bank = {prg[3:1], prg_ain[14]};
            endcase
            prg_aout = {4'b0, prg_bank, prg_ain[13:0]};
        end else if (prg_ain[14:13] == 2'b11) begin
            prg_aout = {WRAM_PREFIX, prg_ain[12:0]};
            wram_ce  = !prg[4];
        end
    end

    always_comb begin
        chr_bank = {chr0[4:1], chr_ain[12]};
        if (control[4]) begin
            chr_bank = chr_ain[12] ? chr1 : chr0;
        end
        chr_aout = {CHR_PREFIX, chr_bank, chr_ain[11:0]};
    end

    always_comb begin
        vram_a10 = 1'b0;
        case (control[1:0])
            2'd0:    vram_a10 = 1'b0;
            2'd1:    vram_a10 = 1'b1;
            2'd2:    vram_a10 = chr_ain[10];
            default: vram_a10 = chr_ain[11];
        endcase
    end

    assign mmc1_chr  = chr0[4:1];
    assign mmc1_aout = prg_aout;

    assign unused_bits = &{1'b0, prg_din[6:1], chr_ain[13]};

endmodule

// File: tb/tb_mmc1_serial_core.sv
// Directed self-checking bench for mmc1_serial_core; expected values are hand-computed.
// Define MMC1_WRITE_FILTER_EN for both files to exercise the write filter.
module tb_mmc1_serial_core;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic [15:0] prg_ain;
    logic [7:0]  prg_din;
    logic        prg_write;
    logic [13:0] chr_ain;
    logic [21:0] prg_aout;
    logic [21:0] chr_aout;
    logic [3:0]  mmc1_chr;
    logic [21:0] mmc1_aout;
    logic        vram_a10;
    logic        wram_ce;

    int checks   = 0;
    int failures = 0;

    mmc1_serial_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .prg_ain   (prg_ain),
        .prg_din   (prg_din),
        .prg_write (prg_write),
        .chr_ain   (chr_ain),
        .prg_aout  (prg_aout),
        .chr_aout  (chr_aout),
        .mmc1_chr  (mmc1_chr),
        .mmc1_aout (mmc1_aout),
        .vram_a10  (vram_a10),
        .wram_ce   (wram_ce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One write followed by an idle ce cycle, so consecutive calls are never adjacent.
    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        prg_ain   = addr;
        prg_din   = data;
        prg_write = 1'b1;
        ce        = 1'b1;
        @(negedge clk);
        prg_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_reg(input logic [15:0] addr, input logic [4:0] bits);
        for (int i = 0; i < 5; i++) begin
            do_write(addr, {7'b0, bits[i]});
        end
    endtask

    task automatic test_reset();
        logic [15:0] addrs [4];
        logic [21:0] exp_prg [4];
        logic        exp_wce [4];
        addrs   = '{16'h8000, 16'hC000, 16'h4020, 16'h6000};
        exp_prg = '{22'h000000, 22'h03C000, 22'h004020, 22'h3C0000};
        exp_wce = '{1'b0, 1'b0, 1'b0, 1'b1};
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            prg_ain = addrs[i];
            #1;
            checks++;
            if (prg_aout !== exp_prg[i] || mmc1_aout !== exp_prg[i]) begin
                $display("[TB] FAIL reset_prg_aout addr=%h got=%h tap=%h exp=%h", addrs[i], prg_aout, mmc1_aout, exp_prg[i]);
                failures++;
            end
            checks++;
            if (wram_ce !== exp_wce[i]) begin
                $display("[TB] FAIL reset_wram_ce addr=%h got=%b exp=%b", addrs[i], wram_ce, exp_wce[i]);
                failures++;
            end
        end
        chr_ain = 14'h1234;
        #1;
        checks++;
        if (chr_aout !== 22'h201234) begin
            $display("[TB] FAIL reset_chr_aout got=%h exp=%h", chr_aout, 22'h201234);
            failures++;
        end
        checks++;
        if (vram_a10 !== 1'b0 || mmc1_chr !== 4'd0) begin
            $display("[TB] FAIL reset_vram_chr got=%b/%h exp=0/0", vram_a10, mmc1_chr);
            failures++;
        end
    endtask

    task automatic test_serial_load();
        do_write(16'hE000, 8'h01);
        do_write(16'hE000, 8'h00);
        do_write(16'h7FFF, 8'h01);
        do_write(16'hE000, 8'h01);
        do_write(16'hE000, 8'h00);
        prg_ain = 16'h8000;
        #1;
        checks++;
        if (prg_aout !== 22'h000000) begin
            $display("[TB] FAIL serial_partial got=%h exp=%h", prg_aout, 22'h000000);
            failures++;
        end
        do_write(16'hE000, 8'h00);
        prg_ain = 16'h8000;
        #1;
        checks++;
        if (prg_aout !== 22'h014000) begin
            $display("[TB] FAIL serial_8000 got=%h exp=%h", prg_aout, 22'h014000);
            failures++;
        end
        prg_ain = 16'hC000;
        #1;
        checks++;
        if (prg_aout !== 22'h03C000) begin
            $display("[TB] FAIL serial_C000 got=%h exp=%h", prg_aout, 22'h03C000);
            failures++;
        end
    endtask

    task automatic test_chr_4k();
        load_reg(16'h8000, 5'b10010);
        load_reg(16'hA000, 5'd3);
        load_reg(16'hC000, 5'd7);
        chr_ain = 14'h1000;
        #1;
        checks++;
        if (chr_aout !== 22'h207000) begin
            $display("[TB] FAIL chr4k_hi got=%h exp=%h", chr_aout, 22'h207000);
            failures++;
        end
        chr_ain = 14'h0000;
        #1;
        checks++;
        if (chr_aout !== 22'h203000 || vram_a10 !== 1'b0) begin
            $display("[TB] FAIL chr4k_lo got=%h/%b exp=%h/0", chr_aout, vram_a10, 22'h203000);
            failures++;
        end
        chr_ain = 14'h0400;
        #1;
        checks++;
        if (vram_a10 !== 1'b1) begin
            $display("[TB] FAIL mirror_a10 got=%b exp=1", vram_a10);
            failures++;
        end
        checks++;
        if (mmc1_chr !== 4'b0001) begin
            $display("[TB] FAIL mmc1_chr got=%h exp=%h", mmc1_chr, 4'b0001);
            failures++;
        end
        prg_ain = 16'hC000;
        #1;
        checks++;
        if (prg_aout !== 22'h014000) begin
            $display("[TB] FAIL prg32k_C000 got=%h exp=%h", prg_aout, 22'h014000);
            failures++;
        end
        prg_ain = 16'h8000;
        #1;
        checks++;
        if (prg_aout !== 22'h010000) begin
            $display("[TB] FAIL prg32k_8000 got=%h exp=%h", prg_aout, 22'h010000);
            failures++;
        end
    endtask

    task automatic test_reset_mid_sequence();
        for (int i = 0; i < 3; i++) begin
            do_write(16'hA000, 8'h01);
        end
        do_write(16'h8000, 8'h80);
        prg_ain = 16'h8000;
        #1;
        checks++;
        if (prg_aout !== 22'h014000) begin
            $display("[TB] FAIL bit7_mode_8000 got=%h exp=%h", prg_aout, 22'h014000);
            failures++;
        end
        prg_ain = 16'hC000;
        #1;
        checks++;
        if (prg_aout !== 22'h03C000) begin
            $display("[TB] FAIL bit7_mode_C000 got=%h exp=%h", prg_aout, 22'h03C000);
            failures++;
        end
        load_reg(16'hA000, 5'b00110);
        #1;
        checks++;
        if (mmc1_chr !== 4'b0011) begin
            $display("[TB] FAIL midseq_chr0 got=%h exp=%h", mmc1_chr, 4'b0011);
            failures++;
        end
        chr_ain = 14'h0000;
        #1;
        checks++;
        if (chr_aout !== 22'h206000) begin
            $display("[TB] FAIL midseq_chr_aout got=%h exp=%h", chr_aout, 22'h206000);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] exp_first;
        logic [21:0] exp_second;
`ifdef MMC1_WRITE_FILTER_EN
        exp_first  = 22'h014000;
        exp_second = 22'h004000;
`else
        exp_first  = 22'h00C000;
        exp_second = 22'h00C000;
`endif
        @(negedge clk);
        prg_ain   = 16'hE000;
        prg_din   = 8'h01;
        prg_write = 1'b1;
        @(negedge clk);
        prg_din   = 8'h01;
        @(negedge clk);
        prg_write = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            do_write(16'hE000, 8'h00);
        end
        prg_ain = 16'h8000;
        #1;
        checks++;
        if (prg_aout !== exp_first) begin
            $display("[TB] FAIL b2b_first got=%h exp=%h", prg_aout, exp_first);
            failures++;
        end
        do_write(16'hE000, 8'h00);
        prg_ain = 16'h8000;
        #1;
        checks++;
        if (prg_aout !== exp_second) begin
            $display("[TB] FAIL b2b_second got=%h exp=%h", prg_aout, exp_second);
            failures++;
        end
    endtask

    task automatic test_async_reset();
        do_write(16'hE000, 8'h80);
        load_reg(16'hE000, 5'b10000);
        prg_ain = 16'h6000;
        #1;
        checks++;
        if (wram_ce !== 1'b0) begin
            $display("[TB] FAIL wram_disabled got=%b exp=0", wram_ce);
            failures++;
        end
        ce = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (wram_ce !== 1'b1) begin
            $display("[TB] FAIL async_wram_ce got=%b exp=1", wram_ce);
            failures++;
        end
        prg_ain = 16'hC000;
        chr_ain = 14'h1234;
        #1;
        checks++;
        if (prg_aout !== 22'h03C000 || chr_aout !== 22'h201234) begin
            $display("[TB] FAIL async_decode got=%h/%h exp=%h/%h", prg_aout, chr_aout, 22'h03C000, 22'h201234);
            failures++;
        end
        checks++;
        if (mmc1_chr !== 4'd0 || vram_a10 !== 1'b0) begin
            $display("[TB] FAIL async_chr_mirror got=%h/%b exp=0/0", mmc1_chr, vram_a10);
            failures++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        ce      = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        ce        = 1'b0;
        prg_ain   = 16'h0000;
        prg_din   = 8'h00;
        prg_write = 1'b0;
        chr_ain   = 14'h0000;
        test_reset();
        test_serial_load();
        test_chr_4k();
        test_reset_mid_sequence();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
